// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache between the fetch stage and the
// memory controller. Misses are filled over the iREN/iwait handshake.
module icache #(
    parameter int SETS   = 16,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [31:0]       imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [31:0]       iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t state, state_next;

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [WORD_W-1:0] data [SETS];

    // The miss address is kept as a word address; the byte offset is always zero.
    logic [29:0]       miss_word;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              lookup_hit;
    logic              start_fill;
    logic              fill_done;
    logic              unused_byte_offset;

    assign idx                = imemaddr[IDX_W+1:2];
    assign req_tag            = imemaddr[31:IDX_W+2];
    assign fill_idx           = miss_word[IDX_W-1:0];
    assign fill_tag           = miss_word[29:IDX_W];
    assign unused_byte_offset = ^imemaddr[1:0];

    assign lookup_hit = imemREN & valid[idx] & (tags[idx] == req_tag);
    assign imemload   = data[idx];
    assign iaddr      = {miss_word, 2'b00};

    always_comb begin
        state_next = state;
        ihit       = 1'b0;
        iREN       = 1'b0;
        start_fill = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                ihit = lookup_hit;
                if (imemREN && !lookup_hit) begin
                    start_fill = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                iREN = 1'b1;
                if (!iwait) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            valid     <= '0;
            miss_word <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state <= state_next;
            if (start_fill) begin
                miss_word <= imemaddr[31:2];
                miss_cnt  <= miss_cnt + 32'd1;
            end
            if (fill_done) begin
                valid[fill_idx] <= 1'b1;
            end
            if (ihit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
        end
    end

    // Tag/data arrays are not cleared, but a reset still blocks a fill landing that cycle.
    always_ff @(posedge CLK) begin
        if (nRST && fill_done) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= iload;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a frame-level behavioural model of the cache.
module tb_icache;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks   = 0;
    int failures = 0;
    bit checks_on = 1'b0;

    // Model: each frame remembers which word address it holds; memory is a fixed function.
    bit          m_valid [16];
    logic [29:0] m_word  [16];
    bit          m_filling;
    logic [31:0] m_pend;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    icache dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial forever #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_000A;
            32'h0000_0004: return 32'h3C00_FFFF;
            32'h0000_0040: return 32'hDEAD_BEEF;
            default:       return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
        endcase
    endfunction

    function automatic int frame_of(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic bit model_hit(input logic ren, input logic [31:0] a);
        return !m_filling && ren && m_valid[frame_of(a)] && (m_word[frame_of(a)] == a[31:2]);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge; returns shortly after so outputs have settled.
    task automatic applyStimulus(input logic ren, input logic [31:0] addr,
                                 input logic wt, input logic rst_n);
        @(negedge CLK);
        nRST     = rst_n;
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        iload    = m_filling ? mem_word(m_pend) : $urandom;
        #3;
    endtask

    always @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            m_filling = 1'b0;
            m_pend    = '0;
            m_hits    = '0;
            m_misses  = '0;
            checks_on = 1'b1;
        end else if (m_filling) begin
            if (!iwait) begin
                m_valid[frame_of(m_pend)] = 1'b1;
                m_word[frame_of(m_pend)]  = m_pend[31:2];
                m_filling = 1'b0;
            end
        end else if (imemREN) begin
            if (model_hit(imemREN, imemaddr)) begin
                m_hits = m_hits + 32'd1;
            end else begin
                m_filling = 1'b1;
                m_pend    = {imemaddr[31:2], 2'b00};
                m_misses  = m_misses + 32'd1;
            end
        end
    end

    always @(negedge CLK) begin
        #2;
        if (checks_on) begin
            checkOutput("ihit", {31'd0, ihit}, {31'd0, model_hit(imemREN, imemaddr)});
            checkOutput("iREN", {31'd0, iREN}, {31'd0, m_filling});
            if (model_hit(imemREN, imemaddr))
                checkOutput("imemload", imemload, mem_word({imemaddr[31:2], 2'b00}));
            if (m_filling)
                checkOutput("iaddr", iaddr, m_pend);
            checkOutput("hit_cnt", hit_cnt, m_hits);
            checkOutput("miss_cnt", miss_cnt, m_misses);
        end
    end

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        iwait    = 1'b1;
        iload    = '0;
        m_filling = 1'b0;
        m_pend    = '0;
        m_hits    = '0;
        m_misses  = '0;

        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 1, 1);
        checkOutput("reset_ihit", {31'd0, ihit}, 32'd0);
        checkOutput("reset_iREN", {31'd0, iREN}, 32'd0);
        checkOutput("reset_iaddr", iaddr, 32'h0);
        checkOutput("reset_hit_cnt", hit_cnt, 32'd0);
        checkOutput("reset_miss_cnt", miss_cnt, 32'd0);

        // Cold miss on 0x0 with two busy cycles.
        applyStimulus(1, 32'h0, 1, 1);
        checkOutput("t1_miss_ihit", {31'd0, ihit}, 32'd0);
        applyStimulus(1, 32'h0, 1, 1);
        checkOutput("t1_iREN", {31'd0, iREN}, 32'd1);
        checkOutput("t1_iaddr", iaddr, 32'h0);
        applyStimulus(1, 32'h0, 1, 1);
        applyStimulus(1, 32'h0, 0, 1);
        applyStimulus(1, 32'h0, 1, 1);
        checkOutput("t1_ihit", {31'd0, ihit}, 32'd1);
        checkOutput("t1_data", imemload, 32'h2008_000A);
        checkOutput("t1_miss_cnt", miss_cnt, 32'd1);
        checkOutput("t1_hit_cnt", hit_cnt, 32'd0);

        applyStimulus(1, 32'h0, 1, 1);
        checkOutput("t2_hit0", {31'd0, ihit}, 32'd1);
        applyStimulus(1, 32'h4, 1, 1);
        applyStimulus(1, 32'h4, 0, 1);
        applyStimulus(1, 32'h4, 1, 1);
        checkOutput("t2_data4", imemload, 32'h3C00_FFFF);
        checkOutput("t2_iREN", {31'd0, iREN}, 32'd0);
        applyStimulus(1, 32'h0, 1, 1);
        checkOutput("t2_data0", imemload, 32'h2008_000A);
        applyStimulus(0, 32'h0, 1, 1);
        checkOutput("t2_hit_cnt", hit_cnt, 32'd4);
        checkOutput("t2_miss_cnt", miss_cnt, 32'd2);

        // 0x40 shares frame 0 with 0x0 and evicts it.
        applyStimulus(1, 32'h40, 1, 1);
        checkOutput("t3_miss40", {31'd0, ihit}, 32'd0);
        applyStimulus(1, 32'h40, 0, 1);
        applyStimulus(1, 32'h40, 1, 1);
        checkOutput("t3_data40", imemload, 32'hDEAD_BEEF);
        applyStimulus(1, 32'h0, 1, 1);
        checkOutput("t3_evicted", {31'd0, ihit}, 32'd0);
        applyStimulus(1, 32'h0, 0, 1);
        checkOutput("t3_iaddr", iaddr, 32'h0);
        applyStimulus(1, 32'h0, 1, 1);
        checkOutput("t3_data0", imemload, 32'h2008_000A);
        checkOutput("t3_miss_cnt", miss_cnt, 32'd4);
        checkOutput("t3_hit_cnt", hit_cnt, 32'd5);

        // Reset lands on the same edge a fill would complete.
        applyStimulus(1, 32'h8, 1, 1);
        applyStimulus(1, 32'h8, 0, 0);
        checkOutput("t5_iREN_fill", {31'd0, iREN}, 32'd1);
        applyStimulus(1, 32'h8, 1, 1);
        checkOutput("t5_no_hit", {31'd0, ihit}, 32'd0);
        checkOutput("t5_iREN_idle", {31'd0, iREN}, 32'd0);
        applyStimulus(1, 32'h8, 0, 1);
        checkOutput("t5_refill", {31'd0, iREN}, 32'd1);
        applyStimulus(1, 32'h8, 1, 1);
        checkOutput("t5_hit", {31'd0, ihit}, 32'd1);

        // Byte offset is ignored.
        applyStimulus(1, 32'h6, 1, 1);
        checkOutput("t4_miss", {31'd0, ihit}, 32'd0);
        applyStimulus(1, 32'h6, 0, 1);
        checkOutput("t4_iaddr", iaddr, 32'h4);
        applyStimulus(1, 32'h6, 1, 1);
        checkOutput("t4_data", imemload, 32'h3C00_FFFF);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 32'h6, 1, 1);
            checkOutput("t6_ihit", {31'd0, ihit}, 32'd0);
            checkOutput("t6_iREN", {31'd0, iREN}, 32'd0);
        end
        checkOutput("t6_hit_cnt", hit_cnt, 32'd2);
        checkOutput("t6_miss_cnt", miss_cnt, 32'd2);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = {(($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0), 8'($urandom)};
            applyStimulus(($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 99) != 0));
        end

        applyStimulus(0, 32'h0, 1, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
